rc4_prga_decrypt: RTL and testbench

RC4_PRGA_DECRYPT -- requirements
Module: rc4_prga_decrypt

---
 rtl/rc4_pkg.sv | 22 ++
 rtl/rc4_counter.sv | 22 ++
 rtl/rc4_prga_decrypt.sv | 129 ++++++++++++
 tb/tb_rc4_prga_decrypt.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rc4_pkg.sv
// Shared RC4 definitions: PRGA state encoding and default message length.
package rc4_pkg;

  localparam int unsigned DefaultMsgLen = 32;

  typedef enum logic [3:0] {
    StIdle,
    StIncI,
    StRdSi,
    StLtSi,
    StRdSj,
    StLtSj,
    StWrSj,
    StWrSi,
    StRdF,
    StLtF,
    StWrDec,
    StNextK,
    StDone
  } prga_state_e;

endpackage

// File: rtl/rc4_counter.sv
// Shared up-counter with synchronous clear and count enable.
module rc4_counter #(
  parameter int unsigned Width = 9
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             en,
  output logic [Width-1:0] count
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (en) begin
      count <= count + Width'(1);
    end
  end

endmodule

// File: rtl/rc4_prga_decrypt.sv
// RC4 PRGA stage: permutes the pre-initialised S RAM and XORs the keystream
// with ciphertext ROM bytes, writing plaintext to the decrypt RAM.
module rc4_prga_decrypt
  import rc4_pkg::*;
#(
  parameter int unsigned MSG_LEN = DefaultMsgLen
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  output logic       done,
  output logic [7:0] s_address,
  output logic [7:0] s_data,
  output logic       s_wren,
  input  logic [7:0] s_q,
  output logic [7:0] rom_address,
  input  logic [7:0] rom_q,
  output logic [7:0] dec_address,
  output logic [7:0] dec_data,
  output logic       dec_wren
);

  // k is 9 bits so that MSG_LEN = 256 still reaches its last index cleanly.
  localparam logic [8:0] LastK = 9'(MSG_LEN - 1);

  prga_state_e state;
  logic [7:0]  i, j, si, sj, f, enc;
  logic [8:0]  k;
  logic        k_clear, k_en, last_k;

  assign last_k  = (k == LastK);
  assign k_clear = ((state == StIdle) || (state == StDone)) && start;
  assign k_en    = (state == StNextK) && !last_k;

  rc4_counter #(
    .Width (9)
  ) u_k_counter (
    .clk   (clk),
    .reset (reset),
    .clear (k_clear),
    .en    (k_en),
    .count (k)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= StIdle;
      i     <= '0;
      j     <= '0;
      si    <= '0;
      sj    <= '0;
      f     <= '0;
      enc   <= '0;
    end else begin
      unique case (state)
        StIdle, StDone: begin
          if (start) begin
            state <= StIncI;
            i     <= '0;
            j     <= '0;
          end
        end
        StIncI: begin
          i     <= i + 8'd1;
          state <= StRdSi;
        end
        StRdSi: state <= StLtSi;
        StLtSi: begin
          si    <= s_q;
          j     <= j + s_q;
          state <= StRdSj;
        end
        StRdSj: state <= StLtSj;
        StLtSj: begin
          sj    <= s_q;
          state <= StWrSj;
        end
        StWrSj: state <= StWrSi;
        StWrSi: state <= StRdF;
        StRdF:  state <= StLtF;
        StLtF: begin
          f     <= s_q;
          enc   <= rom_q;
          state <= StWrDec;
        end
        StWrDec: state <= StNextK;
        StNextK: state <= last_k ? StDone : StIncI;
        default: state <= StIdle;
      endcase
    end
  end

  // Outputs decode from the state register only, so reset clears them at once.
  always_comb begin
    done        = (state == StDone);
    s_address   = '0;
    s_data      = '0;
    s_wren      = 1'b0;
    rom_address = '0;
    dec_address = '0;
    dec_data    = '0;
    dec_wren    = 1'b0;
    unique case (state)
      StRdSi: s_address = i;
      StRdSj: s_address = j;
      StWrSj: begin
        s_address = j;
        s_data    = si;
        s_wren    = 1'b1;
      end
      StWrSi: begin
        s_address = i;
        s_data    = sj;
        s_wren    = 1'b1;
      end
      StRdF: begin
        s_address   = si + sj;
        rom_address = k[7:0];
      end
      StWrDec: begin
        dec_address = k[7:0];
        dec_data    = f ^ enc;
        dec_wren    = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_rc4_prga_decrypt.sv
// Self-checking bench: four DUTs (MSG_LEN 1, 2, 32, 256) with behavioural
// S RAM / ROM / plaintext RAM, checked against a plain-arithmetic RC4 model.
module tb_rc4_prga_decrypt;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset;
  logic [3:0] start;
  logic [3:0] load;
  logic [3:0] done_v, swren_v, decwren_v;

  logic [7:0] s_init   [256];
  logic [7:0] rom_init [256];
  logic [7:0] m_s      [256];
  logic [7:0] m_enc    [256];
  logic [7:0] m_dec    [256];

  int n_cmp  = 0;
  int n_fail = 0;

  for (genvar g = 0; g < 4; g++) begin : g_inst
    logic [7:0] s_address, s_data, s_q, rom_address, rom_q, dec_address, dec_data;
    logic       s_wren, dec_wren, done;
    logic [7:0] s_mem   [256];
    logic [7:0] dec_mem [256];
    int         swren_cnt, decwren_cnt;
    logic [7:0] last_dec_addr;

    rc4_prga_decrypt #(
      .MSG_LEN ((g == 0) ? 1 : (g == 1) ? 2 : (g == 2) ? 32 : 256)
    ) u_dut (
      .clk         (clk),
      .reset       (reset),
      .start       (start[g]),
      .done        (done),
      .s_address   (s_address),
      .s_data      (s_data),
      .s_wren      (s_wren),
      .s_q         (s_q),
      .rom_address (rom_address),
      .rom_q       (rom_q),
      .dec_address (dec_address),
      .dec_data    (dec_data),
      .dec_wren    (dec_wren)
    );

    assign done_v[g]    = done;
    assign swren_v[g]   = s_wren;
    assign decwren_v[g] = dec_wren;

    always @(posedge clk) begin
      s_q   <= s_mem[s_address];
      rom_q <= rom_init[rom_address];
      if (load[g]) begin
        s_mem       <= s_init;
        dec_mem     <= '{default: 8'h00};
        swren_cnt   <= 0;
        decwren_cnt <= 0;
      end else begin
        if (s_wren) begin
          s_mem[s_address] <= s_data;
          swren_cnt        <= swren_cnt + 1;
        end
        if (dec_wren) begin
          dec_mem[dec_address] <= dec_data;
          decwren_cnt          <= decwren_cnt + 1;
          last_dec_addr        <= dec_address;
        end
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Plain RC4 keystream generation over m_s (updated in place), i = j = 0.
  task automatic rc4_model(input int len);
    int ii, jj, t;
    logic [7:0] tmp;
    ii = 0;
    jj = 0;
    for (int n = 0; n < len; n++) begin
      ii = (ii + 1) % 256;
      jj = (jj + int'(m_s[ii])) % 256;
      tmp = m_s[ii]; m_s[ii] = m_s[jj]; m_s[jj] = tmp;
      t = (int'(m_s[ii]) + int'(m_s[jj])) % 256;
      m_dec[n] = m_s[t] ^ m_enc[n];
    end
  endtask

  task automatic ksa_init(input logic [23:0] key);
    int jj;
    logic [7:0] kb [3];
    logic [7:0] tmp;
    kb[0] = key[23:16]; kb[1] = key[15:8]; kb[2] = key[7:0];
    for (int x = 0; x < 256; x++) s_init[x] = 8'(x);
    jj = 0;
    for (int x = 0; x < 256; x++) begin
      jj = (jj + int'(s_init[x]) + int'(kb[x % 3])) % 256;
      tmp = s_init[x]; s_init[x] = s_init[jj]; s_init[jj] = tmp;
    end
  endtask

  task automatic identity_s();
    for (int x = 0; x < 256; x++) s_init[x] = 8'(x);
  endtask

  task automatic random_rom();
    for (int x = 0; x < 256; x++) rom_init[x] = 8'($urandom_range(255, 0));
  endtask

  task automatic prep_model();
    for (int x = 0; x < 256; x++) begin
      m_s[x]   = s_init[x];
      m_enc[x] = rom_init[x];
    end
  endtask

  task automatic do_load(input int idx);
    @(negedge clk); load[idx] = 1'b1;
    @(negedge clk); load[idx] = 1'b0;
  endtask

  task automatic run(input int idx, input int len, output int cycles);
    @(negedge clk); start[idx] = 1'b1;
    @(negedge clk); start[idx] = 1'b0;
    cycles = 0;
    while (!done_v[idx] && cycles < 11 * len + 50) begin
      @(negedge clk);
      cycles++;
    end
  endtask

  int cyc, bad, act;
  logic [7:0] tmp8;

  initial begin
    reset = 1'b1;
    start = '0;
    load  = '0;
    identity_s();
    random_rom();
    #1;
    check("rst_done", 32'(done_v), 32'h0);
    check("rst_swren", 32'(swren_v), 32'h0);
    check("rst_decwren", 32'(decwren_v), 32'h0);
    check("rst_s_addr", 32'(g_inst[3].s_address), 32'h0);
    check("rst_dec_addr", 32'(g_inst[3].dec_address), 32'h0);
    repeat (3) @(negedge clk);
    reset = 1'b0;

    // MSG_LEN=1, identity S: self-swap at i=j=1, f=S[2]=2, 0x42^0x02=0x40.
    identity_s();
    random_rom();
    rom_init[0] = 8'h42;
    do_load(0);
    prep_model();
    rc4_model(1);
    run(0, 1, cyc);
    check("len1_cycles", 32'(cyc), 32'd11);
    check("len1_dec0", 32'(g_inst[0].dec_mem[0]), 32'h40);
    check("len1_dec0_model", 32'(g_inst[0].dec_mem[0]), 32'(m_dec[0]));
    check("len1_swren", 32'(g_inst[0].swren_cnt), 32'd2);
    check("len1_decwren", 32'(g_inst[0].decwren_cnt), 32'd1);
    bad = 0;
    for (int x = 0; x < 256; x++) if (g_inst[0].s_mem[x] !== 8'(x)) bad++;
    check("len1_s_unchanged", 32'(bad), 32'd0);
    repeat (2) @(negedge clk);
    check("len1_done_hold", 32'(done_v[0]), 32'h1);

    // MSG_LEN=2, identity S: byte 1 has i=2, j=3, f=S[5]=5, 0x05^0x05=0.
    rom_init[1] = 8'h05;
    do_load(1);
    prep_model();
    rc4_model(2);
    run(1, 2, cyc);
    check("len2_cycles", 32'(cyc), 32'd22);
    check("len2_dec0", 32'(g_inst[1].dec_mem[0]), 32'(m_dec[0]));
    check("len2_dec1", 32'(g_inst[1].dec_mem[1]), 32'h00);
    check("len2_s2", 32'(g_inst[1].s_mem[2]), 32'h03);
    check("len2_s3", 32'(g_inst[1].s_mem[3]), 32'h02);

    // MSG_LEN=32 with S from key 0x000249.
    ksa_init(24'h000249);
    random_rom();
    do_load(2);
    prep_model();
    rc4_model(32);
    run(2, 32, cyc);
    check("len32_cycles", 32'(cyc), 32'd352);
    for (int n = 0; n < 32; n++)
      check($sformatf("len32_dec[%0d]", n), 32'(g_inst[2].dec_mem[n]), 32'(m_dec[n]));
    bad = 0;
    for (int x = 0; x < 256; x++) if (g_inst[2].s_mem[x] !== m_s[x]) bad++;
    check("len32_s_final", 32'(bad), 32'd0);
    check("len32_swren", 32'(g_inst[2].swren_cnt), 32'd64);
    check("len32_decwren", 32'(g_inst[2].decwren_cnt), 32'd32);

    // Reset during WR_SJ of byte 5 (the 11th s_wren cycle).
    ksa_init(24'h000249);
    random_rom();
    do_load(2);
    @(negedge clk); start[2] = 1'b1;
    @(negedge clk); start[2] = 1'b0;
    cyc = 0;
    while (!(g_inst[2].swren_cnt == 10 && swren_v[2]) && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
    check("rst_mid_reached", 32'(cyc < 200), 32'h1);
    check("rst_mid_pre_swren", 32'(swren_v[2]), 32'h1);
    reset = 1'b1;
    #1;
    check("rst_mid_swren", 32'(swren_v[2]), 32'h0);
    check("rst_mid_decwren", 32'(decwren_v[2]), 32'h0);
    check("rst_mid_done", 32'(done_v[2]), 32'h0);
    check("rst_mid_s_addr", 32'(g_inst[2].s_address), 32'h0);
    check("rst_mid_s_data", 32'(g_inst[2].s_data), 32'h0);
    check("rst_mid_bytes_written", 32'(g_inst[2].decwren_cnt), 32'd5);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    act = 0;
    repeat (6) begin
      @(negedge clk);
      if (swren_v[2] || decwren_v[2] || done_v[2]) act++;
    end
    check("rst_mid_idle", 32'(act), 32'd0);
    random_rom();
    do_load(2);
    prep_model();
    rc4_model(32);
    run(2, 32, cyc);
    check("rerun_cycles", 32'(cyc), 32'd352);
    for (int n = 0; n < 32; n++)
      check($sformatf("rerun_dec[%0d]", n), 32'(g_inst[2].dec_mem[n]), 32'(m_dec[n]));

    // start held high across a run: one DONE cycle, then a fresh run (i=j=0).
    identity_s();
    for (int x = 255; x > 0; x--) begin
      cyc = $urandom_range(x, 0);
      tmp8 = s_init[x]; s_init[x] = s_init[cyc]; s_init[cyc] = tmp8;
    end
    random_rom();
    do_load(1);
    prep_model();
    rc4_model(2);
    @(negedge clk); start[1] = 1'b1;
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!done_v[1] && cyc < 100);
    check("held_first_done", 32'(cyc), 32'd23);
    check("held_run1_dec0", 32'(g_inst[1].dec_mem[0]), 32'(m_dec[0]));
    check("held_run1_dec1", 32'(g_inst[1].dec_mem[1]), 32'(m_dec[1]));
    rc4_model(2);
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
      if (cyc == 1) check("held_done_width", 32'(done_v[1]), 32'h0);
    end while (!done_v[1] && cyc < 100);
    start[1] = 1'b0;
    check("held_second_done", 32'(cyc), 32'd23);
    check("held_run2_dec0", 32'(g_inst[1].dec_mem[0]), 32'(m_dec[0]));
    check("held_run2_dec1", 32'(g_inst[1].dec_mem[1]), 32'(m_dec[1]));
    check("held_swren", 32'(g_inst[1].swren_cnt), 32'd8);
    bad = 0;
    for (int x = 0; x < 256; x++) if (g_inst[1].s_mem[x] !== m_s[x]) bad++;
    check("held_s_final", 32'(bad), 32'd0);

    // MSG_LEN=256 with identity S: i wraps, last write at 0xFF.
    identity_s();
    random_rom();
    do_load(3);
    prep_model();
    rc4_model(256);
    run(3, 256, cyc);
    check("len256_cycles", 32'(cyc), 32'd2816);
    for (int n = 0; n < 256; n++)
      check($sformatf("len256_dec[%0d]", n), 32'(g_inst[3].dec_mem[n]), 32'(m_dec[n]));
    check("len256_last_addr", 32'(g_inst[3].last_dec_addr), 32'hff);
    check("len256_done", 32'(done_v[3]), 32'h1);
    check("len256_swren", 32'(g_inst[3].swren_cnt), 32'd512);
    check("len256_decwren", 32'(g_inst[3].decwren_cnt), 32'd256);
    bad = 0;
    for (int x = 0; x < 256; x++) if (g_inst[3].s_mem[x] !== m_s[x]) bad++;
    check("len256_s_final", 32'(bad), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
